// File: rtl/mp64_mbox_fifo.sv
// MP64 inter-core mailbox (per-core inbound FIFOs with IPI) and owner-tracked spinlock bank.
// Optional broadcast SEND (target 0xFF) is enabled by defining MP64_MBOX_BCAST_EN.
module mp64_mbox_fifo #(
    parameter int NUM_CORES     = 4,
    parameter int CORE_ID_BITS  = 2,
    parameter int FIFO_DEPTH    = 4,
    parameter int NUM_SPINLOCKS = 16
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    req,
    input  logic [11:0]             addr,
    input  logic [7:0]              wdata,
    input  logic                    wen,
    output logic [7:0]              rdata,
    output logic                    ack,
    input  logic [CORE_ID_BITS-1:0] requester_id,
    output logic [NUM_CORES-1:0]    ipi_out
);

    localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CW = PW + 1;

    logic                    mbox_sel;
    logic                    lock_sel;
    logic [5:0]              off;
    logic [3:0]              lk_idx;
    logic [1:0]              lk_sub;
    logic                    lk_valid;
    logic [CORE_ID_BITS-1:0] rid;
    logic [CORE_ID_BITS-1:0] tgt;
    logic                    unused_addr;

    logic [63:0]             stg_q    [NUM_CORES];
    logic [63:0]             pay_mem  [NUM_CORES][FIFO_DEPTH];
    logic [CORE_ID_BITS-1:0] src_mem  [NUM_CORES][FIFO_DEPTH];
    logic [PW-1:0]           wr_ptr_q [NUM_CORES];
    logic [PW-1:0]           wr_ptr_d [NUM_CORES];
    logic [PW-1:0]           rd_ptr_q [NUM_CORES];
    logic [PW-1:0]           rd_ptr_d [NUM_CORES];
    logic [CW-1:0]           count_q  [NUM_CORES];
    logic [CW-1:0]           count_d  [NUM_CORES];
    logic [NUM_CORES-1:0]    ovf_q;
    logic [NUM_CORES-1:0]    ovf_d;
    logic [NUM_CORES-1:0]    err_q;
    logic [NUM_CORES-1:0]    err_d;
    logic [NUM_CORES-1:0]    push_en;
    logic [NUM_CORES-1:0]    full;
    logic [NUM_CORES-1:0]    nonempty;

    logic [NUM_SPINLOCKS-1:0] locked_q;
    logic [NUM_SPINLOCKS-1:0] locked_d;
    logic [CORE_ID_BITS-1:0]  owner_q [NUM_SPINLOCKS];
    logic [CORE_ID_BITS-1:0]  owner_d [NUM_SPINLOCKS];

    logic [63:0]             head_pay;
    logic [CORE_ID_BITS-1:0] head_src;
    logic                    stg_we;

    assign off         = addr[5:0];
    assign lk_idx      = addr[5:2];
    assign lk_sub      = addr[1:0];
    assign rid         = requester_id;
    assign tgt         = wdata[CORE_ID_BITS-1:0];
    assign lk_valid    = int'(lk_idx) < NUM_SPINLOCKS;
    assign mbox_sel    = req && (addr[11:8] == 4'd5);
    assign lock_sel    = req && (addr[11:8] == 4'd6) && lk_valid;
    assign unused_addr = &{1'b0, addr[7:6]};
    assign ack         = 1'b1;
    assign stg_we      = mbox_sel && wen && (off[5:3] == 3'b000);

    always_comb begin
        for (int c = 0; c < NUM_CORES; c++) begin
            nonempty[c] = (count_q[c] != '0);
            full[c]     = (count_q[c] == CW'(FIFO_DEPTH));
            ipi_out[c]  = nonempty[c];
        end
    end

    assign head_pay = pay_mem[rid][rd_ptr_q[rid]];
    assign head_src = src_mem[rid][rd_ptr_q[rid]];

    // Mailbox control: SEND / POP / CLR decode and FIFO pointer next-state.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        ovf_d    = ovf_q;
        err_d    = err_q;
        push_en  = '0;
        if (mbox_sel && wen) begin
            case (off)
                6'h18: begin
`ifdef MP64_MBOX_BCAST_EN
                    if (wdata == 8'hFF) begin
                        for (int c = 0; c < NUM_CORES; c++) begin
                            if (c != int'(rid)) begin
                                if (full[c]) ovf_d[rid] = 1'b1;
                                else         push_en[c] = 1'b1;
                            end
                        end
                    end else
`endif
                    if (int'(wdata) < NUM_CORES) begin
                        if (full[tgt]) ovf_d[rid]   = 1'b1;
                        else           push_en[tgt] = 1'b1;
                    end else begin
                        err_d[rid] = 1'b1;
                    end
                end
                6'h19: begin
                    if (nonempty[rid]) begin
                        rd_ptr_d[rid] = rd_ptr_q[rid] + PW'(1);
                        count_d[rid]  = count_q[rid] - CW'(1);
                    end
                end
                6'h1A: begin
                    ovf_d[rid] = 1'b0;
                    err_d[rid] = 1'b0;
                end
                default: ;
            endcase
        end
        for (int c = 0; c < NUM_CORES; c++) begin
            if (push_en[c]) begin
                wr_ptr_d[c] = wr_ptr_q[c] + PW'(1);
                count_d[c]  = count_q[c] + CW'(1);
            end
        end
    end

    // Spinlocks: ACQUIRE is a read with a side effect; RELEASE honours only the owner.
    always_comb begin
        locked_d = locked_q;
        owner_d  = owner_q;
        if (lock_sel) begin
            if (!wen && (lk_sub == 2'd0) && !locked_q[lk_idx]) begin
                locked_d[lk_idx] = 1'b1;
                owner_d[lk_idx]  = rid;
            end
            if (wen && (lk_sub == 2'd1) && locked_q[lk_idx] && (owner_q[lk_idx] == rid)) begin
                locked_d[lk_idx] = 1'b0;
            end
        end
    end

    always_comb begin
        rdata = 8'h00;
        if (mbox_sel && !wen) begin
            if (off[5:3] == 3'b000) begin
                rdata = stg_q[rid][{off[2:0], 3'b000} +: 8];
            end else if (off[5:3] == 3'b001) begin
                rdata = nonempty[rid] ? head_pay[{off[2:0], 3'b000} +: 8] : 8'h00;
            end else begin
                case (off)
                    6'h10:   rdata = 8'(count_q[rid]);
                    6'h11:   rdata = nonempty[rid] ? 8'(head_src) : 8'h00;
                    6'h12:   rdata = {5'b0, err_q[rid], ovf_q[rid], nonempty[rid]};
                    default: rdata = 8'h00;
                endcase
            end
        end else if (lock_sel && !wen) begin
            case (lk_sub)
                2'd0:    rdata = {7'b0, locked_q[lk_idx] && (owner_q[lk_idx] != rid)};
                2'd2:    rdata = {locked_q[lk_idx], 3'b000, 4'(owner_q[lk_idx])};
                default: rdata = 8'h00;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int c = 0; c < NUM_CORES; c++) begin
                wr_ptr_q[c] <= '0;
                rd_ptr_q[c] <= '0;
                count_q[c]  <= '0;
                stg_q[c]    <= '0;
            end
            ovf_q    <= '0;
            err_q    <= '0;
            locked_q <= '0;
            for (int l = 0; l < NUM_SPINLOCKS; l++) begin
                owner_q[l] <= '0;
            end
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            ovf_q    <= ovf_d;
            err_q    <= err_d;
            locked_q <= locked_d;
            owner_q  <= owner_d;
            if (stg_we) begin
                stg_q[rid][{off[2:0], 3'b000} +: 8] <= wdata;
            end
        end
    end

    // Entry storage needs no reset: reads of an empty FIFO are masked to zero.
    always_ff @(posedge clk) begin
        for (int c = 0; c < NUM_CORES; c++) begin
            if (push_en[c]) begin
                pay_mem[c][wr_ptr_q[c]] <= stg_q[rid];
                src_mem[c][wr_ptr_q[c]] <= rid;
            end
        end
    end

endmodule

// File: doc/mp64_mbox_fifo.md
Name: mp64_mbox_fifo

Overview:
Next-generation inter-core mailbox and spinlock block for the MP64 multi-core SoC, on the MMIO bus behind the arbiter. Each core has an inbound message FIFO of parametrised depth. Each FIFO entry is a 64-bit payload plus the sender's ID. A per-core IPI line stays high while that core's FIFO is non-empty. The block also provides a parametrised bank of owner-tracked hardware test-and-set spinlocks.

Parameters:
NUM_CORES, 4, number of cores, 2..16
CORE_ID_BITS, 2, equals clog2(NUM_CORES)
FIFO_DEPTH, 4, entries per inbound FIFO; power of 2, 2..16
NUM_SPINLOCKS, 16, number of locks, 1..16

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
req  in  1  MMIO request valid
addr  in  12  MMIO offset
wdata  in  8  write byte
wen  in  1  1=write, 0=read
rdata  out  8  read byte (combinational)
ack  out  1  tied 1, single-cycle access
requester_id  in  CORE_ID_BITS  core owning the current grant
ipi_out  out  NUM_CORES  per-core interrupt, high while that core's inbound FIFO is non-empty

Behaviour:
- Reset: rst_n is asynchronous and active-low; clock is clk. Reset clears all FIFOs (pointers 0, count 0), TX staging registers, the ovf/err flags, all lock state and all owners. After reset, rdata=0 and ipi_out=0. Reset mid-operation discards all queued messages.
- Region decode: addr[11:8]==5 selects the mailbox; ==6 selects the spinlocks; anything else reads 0 and ignores writes. Register offset is addr[5:0]. All registers are banked by requester_id.
- Mailbox, write side:
  - 0x00-0x07: TX staging bytes 0..7, little-endian. Readable back.
  - 0x18 SEND: wdata = target ID. Pushes {requester_id, staging} into the target's FIFO.
  - 0x19 POP: any data. Discards the head of the requester's FIFO.
  - 0x1A CLR: clears the requester's ovf and err flags.
- Mailbox, read side:
  - 0x08-0x0F: RX head payload bytes 0..7.
  - 0x10: RX count, zero-extended.
  - 0x11: RX head source ID.
  - 0x12: STATUS = {5'b0, err, ovf, nonempty}.
  - Reads of the RX head registers when the FIFO is empty return 0.
- SEND rules:
  - Target < NUM_CORES and its FIFO not full: entry written at wr_ptr, wr_ptr+1 (mod FIFO_DEPTH), count+1.
  - Target FIFO full: message dropped, sender ovf set (sticky).
  - Target >= NUM_CORES: no push, sender err set (sticky). Value 0xFF is the exception under BCAST_EN.
  - Self-send is legal. The staging register is unchanged by SEND, so repeated SEND resends the same payload.
- POP rules:
  - Non-empty FIFO: rd_ptr+1 (mod FIFO_DEPTH), count-1.
  - Empty FIFO: no effect, no flag set.
- Timing:
  - One MMIO access per cycle, so push and pop never coincide on one FIFO.
  - State updates on the posedge of the req cycle.
  - ipi_out is derived from the registered count, so it rises the cycle after a push-to-empty and falls the cycle after the last POP.
- Spinlocks: lock N occupies offsets N*4..N*4+3. Accesses with N >= NUM_SPINLOCKS read 0 and ignore writes.
  - Read +0 ACQUIRE:
    - Lock free: rdata=0 and, at the edge, locked=1, owner=requester.
    - Held by the requester: rdata=0 (re-entrant, no change).
    - Held by another core: rdata=1, no change.
  - Write +1 RELEASE: clears locked only if requester==owner; otherwise ignored.
  - Read +2 INFO: {locked, 3'b0, owner zero-extended to 4 bits}. Side-effect free.
  - A write to +0 or a read of +1 has no effect.

Optional Feature:
- Macro: MP64_MBOX_BCAST_EN.
- When defined, SEND with wdata=0xFF pushes the staging payload into every core's FIFO except the sender's, all in the same cycle. Any full target is skipped and sets the sender's ovf; the other targets still receive the message.
- When undefined, 0xFF is an invalid target and sets err.

Test Plan:
1. Core1 writes staging 0x1122334455667788, SEND=2 -> next cycle ipi_out[2]=1. Core2 reads 0x08..0x0F = 88,77,...,11; 0x11=1; 0x10=1. POP -> ipi_out[2]=0, count=0.
2. Core0 does FIFO_DEPTH+1 SENDs to core3 with payloads 1..5 -> count=4, core0 ovf=1. Core3 pops payloads 1,2,3,4 in order. Pointers wrap; one further SEND/POP round trip returns the correct payload.
3. Core1 SEND=7 -> core1 STATUS=0x04, no ipi change. CLR -> STATUS=0x00. POP on an empty FIFO -> count stays 0, STATUS=0x00.
4. Core0 ACQUIRE lock 5 -> 0. Core2 ACQUIRE lock 5 -> 1. Core2 RELEASE -> lock still held, INFO=0x80. Core0 re-ACQUIRE -> 0. Core0 RELEASE -> core2 ACQUIRE -> 0, INFO=0x82.
5. With MP64_MBOX_BCAST_EN, core3's FIFO pre-filled to full; core0 SEND=0xFF -> cores 1 and 2 get count+1, core3 unchanged, core0 ovf=1, core0 FIFO unchanged.
6. Assert rst_n low mid-sequence with 3 queued messages and 2 held locks -> ipi_out=0, all counts=0, all INFO=0x00 immediately (asynchronous reset).
